alu_bist_controller: RTL and testbench
======================================

# alu_bist_controller

Built-in self-test initiator for the 32-bit fault-injectable ALU. It drives pseudo-random operand/opcode vectors into the ALU's input port and samples the ALU's result and flag outputs. It checks them against an internal golden model and reports pass/fail, the mismatch count and the first failing vector. It sits beside the ALU under test; the ALU's adder fault-flip controls are driven externally by the fault-campaign harness.

## Interface
- NUM_VECTORS, 256: vectors per run; legal range 1..65535.
- LFSR_SEED, 32'hACE12357: operand LFSR seed, loaded at every start; must be nonzero.

Ports (name, direction, width, meaning):
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a run; sampled only in IDLE.
- busy, out, 1: high from SEED through the last CHECK.
- done, out, 1: one-cycle pulse when a run completes.
- pass, out, 1: high after a run with zero mismatches; cleared at start.
- alu_operandA, out, 32: ALU operand A.
- alu_operandB, out, 32: ALU operand B.
- alu_opcode, out, 5: ALU opcode.
- alu_shiftamt, out, 5: ALU shift amount.
- alu_result, in, 32: ALU data result.
- alu_isNotEqual, in, 1: ALU not-equal flag.
- alu_isLessThan, in, 1: ALU less-than flag.
- fail_count, out, 16: mismatch count; saturates at 16'hFFFF.
- first_fail_vector, out, 16: index of the first failing vector.
- first_fail_opcode, out, 5: opcode of the first failing vector.
- first_fail_result, out, 32: captured alu_result of the first failing vector.

## Operation
- States and transitions:
  - IDLE: start=1 → SEED.
  - SEED: → DRIVE.
  - DRIVE: → CHECK.
  - CHECK: → DRIVE if vec_idx < NUM_VECTORS-1, else → DONE.
  - DONE: → IDLE.
- SEED:
  - lfsr loads LFSR_SEED.
  - vec_idx, fail_count and first_fail_* clear.
  - pass clears to 0.
- Vector k, registered on entry to DRIVE:
  - alu_operandA = lfsr.
  - alu_operandB = {lfsr[15:0], lfsr[31:16]}.
  - alu_shiftamt = lfsr[4:0] ^ lfsr[9:5].
  - alu_opcode = k mod 6, cycling ADD(0), SUB(1), AND(2), OR(3), SLL(4), SRA(5).
- Golden model, 32-bit wrap-around arithmetic:
  - ADD: A+B.
  - SUB: A+~B+1.
  - AND: A&B.
  - OR: A|B.
  - SLL: A<<shamt.
  - SRA: arithmetic right shift of A by shamt.
- CHECK edge:
  - Compare alu_result with the golden value.
  - On mismatch: fail_count increments (saturating).
  - On the first mismatch of the run: first_fail_* capture.
  - Then lfsr advances one step and vec_idx increments.
- LFSR: 32-bit Galois, taps mask 32'h80200003, shifts right; the XOR is applied when bit 0 = 1.
- DONE: pass = (fail_count == 0); done = 1.
- start while busy, or in DONE, is ignored.
- All other results hold until the next SEED.

## Timing
- Reset values:
  - state = IDLE.
  - busy, done, pass = 0.
  - alu_operandA, alu_operandB = 0; alu_opcode, alu_shiftamt = 0.
  - fail_count, first_fail_vector, first_fail_opcode, first_fail_result = 0.
- start high at edge t: busy=1 from t+1.
- First DRIVE is at t+2; each vector takes 2 cycles.
- done pulses at cycle t+2+2·NUM_VECTORS; busy drops in the same cycle.
- The ALU is combinational. Operands are stable for the full DRIVE cycle, and sampling happens at the end of CHECK, so the ALU gets two full cycles to settle.
- reset_n asserted mid-run aborts immediately to the reset values; no done pulse.

## Configuration
- ALU_BIST_FLAGS_EN defined:
  - SUB vectors also check alu_isNotEqual against (A != B).
  - SUB vectors also check alu_isLessThan against signed(A) < signed(B).
  - A flag mismatch counts as one failure per vector, combined with any result mismatch (maximum one increment per vector).
- ALU_BIST_FLAGS_EN undefined: the flag inputs are unused and only alu_result is compared.

## Structure
- Shared package alu_pkg:
  - ALU opcode constants 0..5.
  - LFSR tap mask.
  - BIST state encoding.
- One sub-module, bist_lfsr32: load/advance enables, 32-bit state output.
- The golden model stays inline.

## Test plan
- Fault-free behavioural ALU, NUM_VECTORS=6, start pulse → done 14 cycles after start; pass=1; fail_count=0; opcodes observed 0,1,2,3,4,5 in order.
- ALU model with result bit 0 stuck-at-0 on AND only, NUM_VECTORS=12 → fail_count equals the number of AND vectors with golden bit0=1. If vector 2 fails: first_fail_vector=2, first_fail_opcode=2.
- Adder fault flip enabled on the ALU, NUM_VECTORS=256 → pass=0; fail_count>0; first_fail_opcode ∈ {0,1}.
- ALU_BIST_FLAGS_EN defined, isLessThan inverted in the model → every SUB vector fails. With NUM_VECTORS=6, fail_count=1 and first_fail_vector=1. With the macro undefined, the same stimulus gives pass=1.
- reset_n low during vector 3 → all outputs return to the reset values in the same cycle. A new start reruns identical operands (same LFSR sequence).
- start held high for the whole run → exactly one run and one done pulse; a second run starts only on start sampled in IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/BIST definitions: opcodes, LFSR taps, BIST states.
// Also hosts the Galois LFSR step used by the BIST controller.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// 32-bit right-shifting Galois LFSR with load and advance enables.
// Load wins over advance.
module bist_lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12357
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] lfsr_q
);

  // State register: reload seed or step once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      lfsr_q <= SEED;
    else if (load)
      lfsr_q <= SEED;
    else if (advance)
      lfsr_q <= lfsr_step(lfsr_q);
  end

endmodule

// File: rtl/alu_bist_controller.sv
// BIST initiator for the 32-bit ALU: drives LFSR vectors, checks results.
// Optional flag checking on SUB vectors under ALU_BIST_FLAGS_EN.
module alu_bist_controller
  import alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12357
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  output logic [15:0] fail_count,
  output logic [15:0] first_fail_vector,
  output logic [4:0]  first_fail_opcode,
  output logic [31:0] first_fail_result
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  bist_state_e state_q, state_d;
  logic [15:0] vec_idx;
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_nx;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic        last_vec;
  logic [31:0] golden;
  logic        res_bad;
  logic        flag_bad;
  logic        mismatch;
  logic [15:0] fail_nx;

  bist_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .lfsr_q  (lfsr_q)
  );

  assign lfsr_nx   = lfsr_step(lfsr_q);
  assign last_vec  = (vec_idx == LAST_IDX);
  assign lfsr_load = (state_q == ST_IDLE) && start;
  assign lfsr_adv  = (state_q == ST_CHECK);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SEED;
      ST_SEED: begin
        busy    = 1'b1;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy    = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        busy    = 1'b1;
        state_d = last_vec ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Golden model of the ALU for the registered vector.
  always_comb begin
    golden = 32'h0;
    case (alu_opcode)
      OP_ADD:  golden = alu_operandA + alu_operandB;
      OP_SUB:  golden = alu_operandA + ~alu_operandB + 32'd1;
      OP_AND:  golden = alu_operandA & alu_operandB;
      OP_OR:   golden = alu_operandA | alu_operandB;
      OP_SLL:  golden = alu_operandA << alu_shiftamt;
      OP_SRA:  golden = $signed(alu_operandA) >>> alu_shiftamt;
      default: golden = 32'h0;
    endcase
  end

  assign res_bad = (alu_result != golden);

`ifdef ALU_BIST_FLAGS_EN
  assign flag_bad = (alu_opcode == OP_SUB) &&
    ((alu_isNotEqual != (alu_operandA != alu_operandB)) ||
     (alu_isLessThan !=
      ($signed(alu_operandA) < $signed(alu_operandB))));
`else
  logic unused_flags;
  assign flag_bad     = 1'b0;
  assign unused_flags = alu_isNotEqual ^ alu_isLessThan;
`endif

  assign mismatch = res_bad || flag_bad;
  assign fail_nx  = (mismatch && fail_count != 16'hFFFF)
                  ? fail_count + 16'd1 : fail_count;

  // Vector drive, compare and result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass              <= 1'b0;
      alu_operandA      <= 32'h0;
      alu_operandB      <= 32'h0;
      alu_opcode        <= 5'd0;
      alu_shiftamt      <= 5'd0;
      vec_idx           <= 16'd0;
      fail_count        <= 16'd0;
      first_fail_vector <= 16'd0;
      first_fail_opcode <= 5'd0;
      first_fail_result <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            pass              <= 1'b0;
            vec_idx           <= 16'd0;
            fail_count        <= 16'd0;
            first_fail_vector <= 16'd0;
            first_fail_opcode <= 5'd0;
            first_fail_result <= 32'h0;
          end
        end
        ST_SEED: begin
          alu_operandA <= lfsr_q;
          alu_operandB <= {lfsr_q[15:0], lfsr_q[31:16]};
          alu_shiftamt <= lfsr_q[4:0] ^ lfsr_q[9:5];
          alu_opcode   <= OP_ADD;
        end
        ST_CHECK: begin
          fail_count <= fail_nx;
          if (mismatch && fail_count == 16'd0) begin
            first_fail_vector <= vec_idx;
            first_fail_opcode <= alu_opcode;
            first_fail_result <= alu_result;
          end
          vec_idx <= vec_idx + 16'd1;
          if (last_vec) begin
            pass <= (fail_nx == 16'd0);
          end else begin
            alu_operandA <= lfsr_nx;
            alu_operandB <= {lfsr_nx[15:0], lfsr_nx[31:16]};
            alu_shiftamt <= lfsr_nx[4:0] ^ lfsr_nx[9:5];
            alu_opcode   <= (alu_opcode == OP_SRA)
                          ? OP_ADD : alu_opcode + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_controller.sv
// Directed bench for alu_bist_controller with a fault-injectable ALU model.
// Fault modes: 0 none, 1 AND bit0 stuck-0, 2 adder bit0 flip, 3 lt inverted.
module tb_alu_bist_controller;

  localparam int N = 12;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic [4:0]  alu_opcode, alu_shiftamt;
  logic        alu_isNotEqual, alu_isLessThan;
  logic [15:0] fail_count, first_fail_vector;
  logic [4:0]  first_fail_opcode;
  logic [31:0] first_fail_result;

  int fault_mode = 0;
  int total = 0;
  int passes = 0;
  int fails = 0;

  logic [31:0] exp_a [N];
  logic [4:0]  exp_op [N];

  alu_bist_controller #(
    .NUM_VECTORS (N),
    .LFSR_SEED   (32'hACE12357)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .alu_operandA      (alu_operandA),
    .alu_operandB      (alu_operandB),
    .alu_opcode        (alu_opcode),
    .alu_shiftamt      (alu_shiftamt),
    .alu_result        (alu_result),
    .alu_isNotEqual    (alu_isNotEqual),
    .alu_isLessThan    (alu_isLessThan),
    .fail_count        (fail_count),
    .first_fail_vector (first_fail_vector),
    .first_fail_opcode (first_fail_opcode),
    .first_fail_result (first_fail_result)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_res(
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] op, input logic [4:0] sh
  );
    logic signed [31:0] sa;
    sa = a;
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return 32'(sa >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] op, input logic [4:0] sh, input int mode
  );
    logic [31:0] r;
    r = ref_res(a, b, op, sh);
    if (mode == 1 && op == 5'd2) r[0] = 1'b0;
    if (mode == 2 && (op == 5'd0 || op == 5'd1)) r[0] = ~r[0];
    return r;
  endfunction

  always_comb begin
    alu_result = alu_model(alu_operandA, alu_operandB,
                           alu_opcode, alu_shiftamt, fault_mode);
    alu_isNotEqual = (alu_operandA != alu_operandB);
    alu_isLessThan = ($signed(alu_operandA) < $signed(alu_operandB));
    if (fault_mode == 3) alu_isLessThan = ~alu_isLessThan;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_run(input int mode,
                           output int ef, output int ev,
                           output int eo, output logic [31:0] er);
    logic [31:0] s, a, b, r, g;
    logic [4:0]  sh, op;
    logic        bad;
    s  = 32'hACE12357;
    ef = 0; ev = 0; eo = 0; er = 32'h0;
    for (int k = 0; k < N; k++) begin
      a  = s;
      b  = {s[15:0], s[31:16]};
      sh = s[4:0] ^ s[9:5];
      op = 5'(k % 6);
      exp_a[k]  = a;
      exp_op[k] = op;
      g   = ref_res(a, b, op, sh);
      r   = alu_model(a, b, op, sh, mode);
      bad = (r != g);
`ifdef ALU_BIST_FLAGS_EN
      if (op == 5'd1 && mode == 3) bad = 1'b1;
`endif
      if (bad) begin
        if (ef == 0) begin
          ev = k; eo = int'(op); er = r;
        end
        ef++;
      end
      s = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    end
  endtask

  task automatic run(input int mode, input bit hold, input string nm);
    int ef, ev, eo, c;
    logic [31:0] er;
    bit seen;
    model_run(mode, ef, ev, eo, er);
    fault_mode = mode;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    c = 1;
    seen = 1'b0;
    repeat (4 * N + 10) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      if (c == 1) chk({nm, "_busy_rise"}, busy, 1'b1);
      if (c >= 2 && c < 2 + 2 * N && c % 2 == 0) begin
        chk({nm, "_opA"}, alu_operandA, exp_a[(c - 2) / 2]);
        chk({nm, "_op"}, alu_opcode, exp_op[(c - 2) / 2]);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      c++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, seen, 1'b1);
    chk({nm, "_done_cycle"}, c, 2 + 2 * N);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    chk({nm, "_pass"}, pass, (ef == 0));
    chk({nm, "_fail_count"}, fail_count, ef);
    chk({nm, "_ff_vec"}, first_fail_vector, ev);
    chk({nm, "_ff_op"}, first_fail_opcode, eo);
    chk({nm, "_ff_res"}, first_fail_result, er);
    @(negedge clock);
    chk({nm, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_opA", alu_operandA, 32'h0);
    chk("rst_fail", fail_count, 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    run(0, 1'b0, "clean");
    chk("clean_pass_hold", pass, 1'b1);

    run(2, 1'b0, "adder");
    chk("adder_fc_hand", fail_count, 16'd4);
    chk("adder_ffv_hand", first_fail_vector, 16'd0);
    chk("adder_ffop_hand", first_fail_opcode, 5'd0);
    chk("adder_ffres_hand", first_fail_result, 32'hD038D039);

    run(1, 1'b0, "and_stuck");

    run(3, 1'b0, "lt_inv");
`ifdef ALU_BIST_FLAGS_EN
    chk("lt_inv_fc_hand", fail_count, 16'd2);
    chk("lt_inv_ffv_hand", first_fail_vector, 16'd1);
`else
    chk("lt_inv_pass_hand", pass, 1'b1);
`endif

    // First vector hand values from the seed.
    fault_mode = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("v0_opA_hand", alu_operandA, 32'hACE12357);
    chk("v0_opB_hand", alu_operandB, 32'h2357ACE1);
    chk("v0_sh_hand", alu_shiftamt, 5'h0D);
    repeat (2) @(negedge clock);
    chk("v1_opA_hand", alu_operandA, 32'hD65091A8);
    chk("v1_op_hand", alu_opcode, 5'd1);

    // Abort mid-run with reset during vector 3.
    repeat (2 * N + 4) @(negedge clock);
    fault_mode = 2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("pre_rst_op", alu_opcode, 5'd3);
    chk("pre_rst_fc", fail_count, 16'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_opA", alu_operandA, 32'h0);
    chk("abort_opB", alu_operandB, 32'h0);
    chk("abort_op", alu_opcode, 5'd0);
    chk("abort_sh", alu_shiftamt, 5'd0);
    chk("abort_fc", fail_count, 16'd0);
    chk("abort_ffv", first_fail_vector, 16'd0);
    chk("abort_ffres", first_fail_result, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run(0, 1'b0, "rerun");

    // Start held for the entire run: one run, one done pulse.
    run(0, 1'b1, "held");
    repeat (3) begin
      @(negedge clock);
      chk("held_no_rerun", busy, 1'b0);
      chk("held_no_done", done, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
